// File: rtl/cla_pkg.sv
// Shared carry-lookahead constants and group generate/propagate helpers.
package cla_pkg;

    localparam int CLA_GRP = 4;

    // Group generate: carry out of a group when its carry-in is 0.
    function automatic logic cla_grp_g(input logic [CLA_GRP-1:0] g,
                                       input logic [CLA_GRP-1:0] p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < CLA_GRP; i++)
            r = g[i] | (p[i] & r);
        return r;
    endfunction

    function automatic logic cla_grp_p(input logic [CLA_GRP-1:0] p);
        return &p;
    endfunction

    // Per-bit carries inside one group, bit 0 receives the group carry-in.
    function automatic logic [CLA_GRP-1:0] cla_carries(input logic [CLA_GRP-1:0] g,
                                                       input logic [CLA_GRP-1:0] p,
                                                       input logic cin);
        logic [CLA_GRP-1:0] c;
        c[0] = cin;
        for (int i = 1; i < CLA_GRP; i++)
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        return c;
    endfunction

endpackage

// File: rtl/cla_half.sv
// Combinational W-bit carry-lookahead adder built from CLA_GRP-bit lookahead groups.
module cla_half
    import cla_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    localparam int NG = W / CLA_GRP;

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W-1:0] w_c;
    logic [NG:0]  w_gc;

    assign w_g     = x & y;
    assign w_p     = x ^ y;
    assign w_gc[0] = cin;

    // Group carries use group G/P so only one level is serial per group.
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        assign w_gc[gi+1] = cla_grp_g(w_g[gi*CLA_GRP +: CLA_GRP], w_p[gi*CLA_GRP +: CLA_GRP])
                          | (cla_grp_p(w_p[gi*CLA_GRP +: CLA_GRP]) & w_gc[gi]);
        assign w_c[gi*CLA_GRP +: CLA_GRP] =
            cla_carries(w_g[gi*CLA_GRP +: CLA_GRP], w_p[gi*CLA_GRP +: CLA_GRP], w_gc[gi]);
    end

    assign s    = w_p ^ w_c;
    assign cout = w_gc[NG];

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined CLA subtractor d = a - b - bi with valid/ready handshake.
// Define CLA_SUB_OVF_EN to add the registered signed-overflow output ovf.
module cla_sub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef CLA_SUB_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int H = WIDTH / 2;

    logic [2:1]       r_vld_pipe;
    logic [H-1:0]     r_s1_lo;
    logic             r_s1_c;
    logic [H-1:0]     r_s1_ahi;
    logic [H-1:0]     r_s1_nbhi;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;

    logic             w_adv1;
    logic             w_adv2;
    logic [WIDTH-1:0] w_nb;
    logic             w_cin;
    logic [H-1:0]     w_lo;
    logic             w_lo_c;
    logic [H-1:0]     w_hi;
    logic             w_hi_c;

    assign w_adv2   = ~r_vld_pipe[2] | out_ready;
    assign w_adv1   = ~r_vld_pipe[1] | w_adv2;
    assign in_ready = w_adv1;

    // Subtraction as a + ~b + ~bi; borrow is the inverted final carry.
    assign w_nb  = ~b;
    assign w_cin = ~bi;

    cla_half #(.W(H)) u_lo (
        .x    (a[H-1:0]),
        .y    (w_nb[H-1:0]),
        .cin  (w_cin),
        .s    (w_lo),
        .cout (w_lo_c)
    );

    cla_half #(.W(H)) u_hi (
        .x    (r_s1_ahi),
        .y    (r_s1_nbhi),
        .cin  (r_s1_c),
        .s    (w_hi),
        .cout (w_hi_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_s1_lo    <= '0;
            r_s1_c     <= 1'b0;
            r_s1_ahi   <= '0;
            r_s1_nbhi  <= '0;
            r_d        <= '0;
            r_bo       <= 1'b0;
        end else begin
            if (w_adv1)
                r_vld_pipe[1] <= in_valid;
            if (w_adv1 && in_valid) begin
                r_s1_lo   <= w_lo;
                r_s1_c    <= w_lo_c;
                r_s1_ahi  <= a[WIDTH-1:H];
                r_s1_nbhi <= w_nb[WIDTH-1:H];
            end
            if (w_adv2)
                r_vld_pipe[2] <= r_vld_pipe[1];
            if (w_adv2 && r_vld_pipe[1]) begin
                r_d  <= {w_hi, r_s1_lo};
                r_bo <= ~w_hi_c;
            end
        end
    end

    assign out_valid = r_vld_pipe[2];
    assign d         = r_d;
    assign bo        = r_bo;

`ifdef CLA_SUB_OVF_EN
    // Operand signs differ when a's MSB equals the MSB of ~b.
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = (r_s1_ahi[H-1] == r_s1_nbhi[H-1]) & (w_hi[H-1] != r_s1_ahi[H-1]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_adv2 && r_vld_pipe[1])
            r_ovf <= w_ovf;
    end

    assign ovf = r_ovf;
`endif

endmodule
